// File: rtl/jpeg_bit_packer.sv
// JPEG entropy-stream bit packer: merges DC/AC codewords MSB-first into bytes,
// inserts 0x00 after every 0xFF, and pads the final partial byte with 1s on flush.
module jpeg_bit_packer #(
    parameter int ACC_W = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        dc_valid,
    input  logic [23:0] jpeg_dc_out,
    input  logic [7:0]  dc_length,
    input  logic        jpeg_out_enable,
    input  logic [15:0] huffman_code,
    input  logic [7:0]  huffman_code_length,
    input  logic        flush,
    output logic        in_ready,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic [7:0]  byte_out,
    output logic        flush_done,
    output logic        len_err
);

    localparam int CNT_W = 7;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STUFF = 2'd1,
        PAD   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               flush_q, flush_d;
    logic               len_err_q, len_err_d;
    logic               byte_valid_q, byte_valid_d;
    logic [7:0]         byte_out_q, byte_out_d;
    logic               flush_done_q, flush_done_d;

    logic               hs;
    logic               dc_take, dc_bad, ac_take, ac_bad;
    logic [CNT_W-1:0]   dc_len, ac_len, cnt_s, cnt_rem;
    logic [ACC_W-1:0]   acc_s, dc_ins, ac_ins;

    assign in_ready   = (state_q == RUN) && (cnt_q <= 7'd24) && !flush_q;
    assign byte_valid = byte_valid_q;
    assign byte_out   = byte_out_q;
    assign flush_done = flush_done_q;
    assign len_err    = len_err_q;

    always_comb begin
        hs      = byte_valid_q & byte_ready;
        dc_take = in_ready & dc_valid & (dc_length <= 8'd24);
        dc_bad  = in_ready & dc_valid & (dc_length > 8'd24);
        ac_take = in_ready & jpeg_out_enable & (huffman_code_length <= 8'd16);
        ac_bad  = in_ready & jpeg_out_enable & (huffman_code_length > 8'd16);
        dc_len  = dc_take ? dc_length[CNT_W-1:0] : '0;
        ac_len  = ac_take ? huffman_code_length[CNT_W-1:0] : '0;
        acc_s   = hs ? (acc_q << 8) : acc_q;
        cnt_s   = hs ? (cnt_q - 7'd8) : cnt_q;
        // Left-justifying the code pushes any bits above its length off the top,
        // so garbage above the length needs no explicit mask; length 0 inserts nothing.
        dc_ins  = ({jpeg_dc_out, {(ACC_W-24){1'b0}}} << (7'd24 - dc_len)) >> cnt_s;
        ac_ins  = ({huffman_code, {(ACC_W-16){1'b0}}} << (7'd16 - ac_len)) >> (cnt_s + dc_len);
        cnt_rem = (cnt_q > 7'd8) ? (cnt_q - 7'd8) : '0;

        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        flush_d   = flush_q;
        len_err_d = len_err_q | dc_bad | ac_bad;

        case (state_q)
            RUN: begin
                acc_d = acc_s | dc_ins | ac_ins;
                cnt_d = cnt_s + dc_len + ac_len;
                if (hs && byte_out_q == 8'hFF) begin
                    state_d = STUFF;
                end else if (flush_q && cnt_q < 7'd8) begin
                    state_d = PAD;
                end
                if (in_ready && flush) begin
                    flush_d = 1'b1;
                end
            end
            STUFF: begin
                if (hs) begin
                    state_d = flush_q ? PAD : RUN;
                end
            end
            PAD: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else if (hs) begin
                    acc_d = acc_q << 8;
                    cnt_d = cnt_rem;
                    if (byte_out_q == 8'hFF) begin
                        state_d = STUFF;
                    end else if (cnt_rem == '0) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = RUN;
                flush_d = 1'b0;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // Outputs are registered images of the next state, so they change
        // exactly when the state they describe becomes current.
        byte_valid_d = ((state_d == RUN) && (cnt_d >= 7'd8)) ||
                       (state_d == STUFF) ||
                       ((state_d == PAD) && (cnt_d != '0));
        if (state_d == STUFF) begin
            byte_out_d = 8'h00;
        end else if ((state_d == PAD) && (cnt_d < 7'd8)) begin
            byte_out_d = acc_d[ACC_W-1 -: 8] | (8'hFF >> cnt_d);
        end else begin
            byte_out_d = acc_d[ACC_W-1 -: 8];
        end
        flush_done_d = (state_d == DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RUN;
            acc_q        <= '0;
            cnt_q        <= '0;
            flush_q      <= 1'b0;
            len_err_q    <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_out_q   <= 8'h00;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            flush_q      <= flush_d;
            len_err_q    <= len_err_d;
            byte_valid_q <= byte_valid_d;
            byte_out_q   <= byte_out_d;
            flush_done_q <= flush_done_d;
        end
    end

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// Scoreboard bench for jpeg_bit_packer: a bit-queue model builds the expected
// byte stream (stuffing, padding, flush markers); a monitor pops on every handshake.
module tb_jpeg_bit_packer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        dc_valid = 1'b0;
    logic [23:0] jpeg_dc_out = '0;
    logic [7:0]  dc_length = '0;
    logic        jpeg_out_enable = 1'b0;
    logic [15:0] huffman_code = '0;
    logic [7:0]  huffman_code_length = '0;
    logic        flush = 1'b0;
    logic        in_ready;
    logic        byte_valid;
    logic        byte_ready = 1'b1;
    logic [7:0]  byte_out;
    logic        flush_done;
    logic        len_err;

    jpeg_bit_packer #(.ACC_W(64)) dut (
        .clock(clock), .reset_n(reset_n),
        .dc_valid(dc_valid), .jpeg_dc_out(jpeg_dc_out), .dc_length(dc_length),
        .jpeg_out_enable(jpeg_out_enable), .huffman_code(huffman_code),
        .huffman_code_length(huffman_code_length), .flush(flush),
        .in_ready(in_ready), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .byte_out(byte_out), .flush_done(flush_done), .len_err(len_err)
    );

    always #5 clock = ~clock;

    int   total = 0;
    int   bad = 0;
    bit   q_bits[$];
    int   exp_q[$];      // 0..255 = byte, 256 = flush_done marker
    bit   exp_len_err = 1'b0;
    int   ready_mode = 1; // 0 random, 1 always ready, 2 stalled

    task automatic check(string name, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_bits(logic [23:0] code, int len);
        for (int i = len - 1; i >= 0; i--) q_bits.push_back(code[i]);
    endtask

    task automatic model_drain();
        int b;
        while (q_bits.size() >= 8) begin
            b = 0;
            for (int i = 0; i < 8; i++) b = (b << 1) | int'(q_bits.pop_front());
            exp_q.push_back(b);
            if (b == 255) exp_q.push_back(0);
        end
    endtask

    task automatic model_flush();
        while ((q_bits.size() % 8) != 0) q_bits.push_back(1'b1);
        model_drain();
        exp_q.push_back(256);
    endtask

    task automatic model_clear();
        q_bits.delete();
        exp_q.delete();
        exp_len_err = 1'b0;
    endtask

    task automatic send(bit dcv, logic [23:0] dc, int dcl,
                        bit acv, logic [15:0] ac, int acl, bit fl);
        int waitc;
        waitc = 0;
        @(negedge clock);
        dc_valid = dcv; jpeg_dc_out = dc; dc_length = dcl[7:0];
        jpeg_out_enable = acv; huffman_code = ac; huffman_code_length = acl[7:0];
        flush = fl;
        while (!in_ready && waitc < 3000) begin
            @(negedge clock);
            waitc++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", in_ready, 1);
        end else begin
            @(posedge clock);
            if (dcv) begin
                if (dcl > 24) exp_len_err = 1'b1;
                else model_bits(dc, dcl);
            end
            if (acv) begin
                if (acl > 16) exp_len_err = 1'b1;
                else model_bits({8'h00, ac}, acl);
            end
            model_drain();
            if (fl) model_flush();
            $display("txn dc=%0d:%0d/%h ac=%0d:%0d/%h flush=%0d", dcv, dcl, dc, acv, acl, ac, fl);
            #1;
        end
        dc_valid = 1'b0; jpeg_out_enable = 1'b0; flush = 1'b0;
    endtask

    // Downstream readiness, changed away from both clock edges.
    initial begin
        forever begin
            @(posedge clock);
            #2;
            case (ready_mode)
                0:       byte_ready = ($urandom_range(0, 3) != 0);
                2:       byte_ready = 1'b0;
                default: byte_ready = 1'b1;
            endcase
        end
    end

    // Monitor: compares every handshaken byte and every flush_done pulse.
    bit       prev_stall = 1'b0;
    logic [7:0] prev_byte = '0;
    initial begin
        int e;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", byte_valid, 1);
                    check("hold_byte", byte_out, prev_byte);
                end
                if (byte_valid && byte_ready) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                    check("byte", byte_out, e);
                end
                if (flush_done) begin
                    e = (exp_q.size() > 0) ? exp_q[0] : -1;
                    check("flush_done_order", e, 256);
                    if (e == 256) void'(exp_q.pop_front());
                end
                check("len_err", len_err, exp_len_err);
                prev_stall = byte_valid && !byte_ready;
                prev_byte  = byte_out;
            end
        end
    end

    initial begin
        int w;
        int dcl, acl;
        bit dcv, acv, fl;

        #3;
        check("rst_byte_valid", byte_valid, 0);
        check("rst_flush_done", flush_done, 0);
        #20 reset_n = 1'b1;
        @(negedge clock);
        check("rst_in_ready", in_ready, 1);
        check("rst_len_err", len_err, 0);

        // 1010 + 1111 -> 0xAF, then empty
        send(0, 0, 0, 1, 16'h000A, 4, 0);
        send(0, 0, 0, 1, 16'h000F, 4, 0);
        @(negedge clock);
        check("af_valid", byte_valid, 1);
        check("af_byte", byte_out, 8'hAF);
        @(negedge clock);
        check("af_empty", byte_valid, 0);

        // 0xFF must be followed by stuffed 0x00 on the next cycle
        send(1, 24'h0000FF, 8, 0, 0, 0, 0);
        @(negedge clock);
        check("ff_byte", byte_out, 8'hFF);
        @(negedge clock);
        check("stuff_valid", byte_valid, 1);
        check("stuff_byte", byte_out, 8'h00);
        @(negedge clock);
        check("stuff_empty", byte_valid, 0);

        // 101 + flush -> 0xBF padded, then single-cycle flush_done
        send(0, 0, 0, 1, 16'h0005, 3, 0);
        send(0, 0, 0, 0, 0, 0, 1);
        @(negedge clock);
        check("flush_in_ready_low", in_ready, 0);
        @(negedge clock);
        check("pad_valid", byte_valid, 1);
        check("pad_byte", byte_out, 8'hBF);
        @(negedge clock);
        check("flush_done_pulse", flush_done, 1);
        @(negedge clock);
        check("flush_done_width", flush_done, 0);
        check("run_after_done", in_ready, 1);

        // Backpressure: two 16-bit codes fill past 24 bits
        ready_mode = 2;
        repeat (2) @(negedge clock);
        send(0, 0, 0, 1, 16'h1234, 16, 0);
        send(0, 0, 0, 1, 16'hABCD, 16, 0);
        @(negedge clock);
        check("bp_in_ready", in_ready, 0);
        check("bp_byte", byte_out, 8'h12);
        repeat (3) @(negedge clock);
        check("bp_stable", byte_out, 8'h12);
        ready_mode = 1;
        send(0, 0, 0, 1, 16'hFF00, 16, 0);
        send(0, 0, 0, 1, 16'h5A5A, 16, 0);

        // Illegal AC length is dropped and sticks in len_err
        send(0, 0, 0, 1, 16'hFFFF, 17, 0);
        @(negedge clock);
        check("len17_err", len_err, 1);
        send(0, 0, 0, 1, 16'h003C, 8, 0);
        w = 0;
        while (exp_q.size() != 0 && w < 200) begin @(negedge clock); w++; end
        check("pre_reset_drain", exp_q.size(), 0);

        // Reset with 13 bits held: outputs clear at once, nothing re-emitted
        ready_mode = 2;
        repeat (2) @(negedge clock);
        send(0, 0, 0, 1, 16'h1ABC, 13, 0);
        @(negedge clock);
        check("mid_valid", byte_valid, 1);
        @(posedge clock);
        #3 reset_n = 1'b0;
        model_clear();
        #1;
        check("async_rst_valid", byte_valid, 0);
        check("async_rst_len_err", len_err, 0);
        check("async_rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clock);
        #3 reset_n = 1'b1;
        ready_mode = 1;
        repeat (5) @(negedge clock);
        check("post_rst_quiet", byte_valid, 0);

        // Randomized traffic against the model
        ready_mode = 0;
        for (int n = 0; n < 300; n++) begin
            dcv = ($urandom_range(0, 2) == 0);
            acv = ($urandom_range(0, 3) != 0);
            dcl = ($urandom_range(0, 39) == 0) ? $urandom_range(25, 40) : $urandom_range(0, 24);
            acl = ($urandom_range(0, 39) == 0) ? $urandom_range(17, 30) : $urandom_range(0, 16);
            fl  = ($urandom_range(0, 24) == 0);
            send(dcv, 24'($urandom), dcl, acv, 16'($urandom), acl, fl);
        end

        ready_mode = 1;
        send(0, 0, 0, 0, 0, 0, 1);
        w = 0;
        while (exp_q.size() != 0 && w < 5000) begin @(negedge clock); w++; end
        check("final_drain", exp_q.size(), 0);
        repeat (3) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
